// File: rtl/optical_rx_pkg.sv
// Shared frame constants and state encoding for the optical link receive path.
package optrx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;

endpackage

// File: rtl/optical_rx_sync.sv
// Two-flop synchronizer for the raw optical line; also reports once the
// pipeline holds real line samples rather than its reset fill.
module rx_sync
  import optrx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic filled
);

  logic [1:0] sync;
  logic [1:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {2{LINE_IDLE}};
      fill <= 2'b00;
    end else begin
      sync <= {sync[0], d};
      fill <= {fill[0], 1'b1};
    end
  end

  assign q      = sync[1];
  assign filled = fill[1];

endmodule

// File: rtl/optical_rx.sv
// Oversampling receiver for the optical frame stream (idle low, start high,
// LSB-first data, stop low). Define OPTRX_MAJORITY_EN for 3-sample voting.
module optical_rx
  import optrx_pkg::*;
#(
  parameter int OVS    = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CYC_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              rx_s;
  logic              filled;
  logic              bit_val;
  state_t            state;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              armed;

  rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (rx_in),
    .q      (rx_s),
    .filled (filled)
  );

`ifdef OPTRX_MAJORITY_EN
  // Decisions land one cycle after the centre so all three votes are in hand.
  localparam logic [CW-1:0] CYC_CTR = CW'(OVS / 2);
  logic rx_d1, rx_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= LINE_IDLE;
      rx_d2 <= LINE_IDLE;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign bit_val = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  localparam logic [CW-1:0] CYC_CTR = CW'(OVS / 2 - 1);
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      // Ignore the synchronizer's reset fill so a line held high at reset
      // release cannot arm the receiver.
      if (filled && rx_s == LINE_IDLE)
        armed <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && rx_s == LINE_START) begin
            state   <= START;
            cyc_cnt <= '0;
          end
        end
        START: begin
          if (cyc_cnt == CYC_CTR) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            state   <= (bit_val == LINE_START) ? DATA : IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            shreg   <= {bit_val, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST)
              state <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            state   <= IDLE;
            if (bit_val == LINE_STOP) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/optical_rx.md
Name: optical_rx

Overview:
- Receive-side decoder for the optical link. It consumes the serial frame stream produced by the transmit pattern generator, after the photodetector/comparator.
- Frame format: line idles low; start bit high; 8 data bits LSB first; stop bit low.
- Oversamples the line, locates bit centres and reassembles the byte.
- Outputs the byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- OVS, 8: rx clk cycles per bit period. Must be even and >= 4.
- DATA_W, 8: data bits per frame.

Ports:
- clk  input  1  receive clock, OVS times the bit rate.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  raw optical line, asynchronous to clk.
- data_out  output  DATA_W  last good byte.
- data_valid  output  1  one-cycle strobe; data_out is updated on the same cycle.
- frame_err  output  1  one-cycle strobe on a bad stop bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock, reset and reset values:
  - Clock clk. Reset rst_n, asynchronous, active-low.
  - Reset values: data_out=0, data_valid=0, frame_err=0, busy=0. State=IDLE, counters=0, armed=0.
- Input synchronisation:
  - rx_in passes through a 2-flop synchronizer; its output is rx_s.
  - All decisions use rx_s only.
- Arming:
  - After reset, armed=0 until rx_s=0 has been seen for 1 cycle.
  - This prevents a false start when reset is released mid-frame.
- Counters:
  - cyc_cnt: $clog2(OVS) bits, counts clk cycles within a bit.
  - bit_cnt: $clog2(DATA_W) bits, counts data bits.
- State machine:
  - IDLE: if armed and rx_s=1, go to START with cyc_cnt=0. Call this edge t0.
  - START: cyc_cnt increments each cycle. At cyc_cnt=OVS/2-1 (centre, edge t0+OVS/2):
    - rx_s=1: go to DATA, cyc_cnt=0, bit_cnt=0.
    - rx_s=0: glitch; go to IDLE with no strobe.
  - DATA: sample at cyc_cnt=OVS-1 (edge t0+OVS/2+(k+1)*OVS for bit k).
    - Shift the sample into the shift register MSB; the register shifts right, so the LSB arrives first.
    - bit_cnt increments; cyc_cnt wraps to 0.
    - After bit DATA_W-1, go to STOP.
  - STOP: sample at cyc_cnt=OVS-1 (edge t0+OVS/2+(DATA_W+1)*OVS).
    - rx_s=0: data_out<=shift register and data_valid=1 for the next cycle.
    - rx_s=1: frame_err=1 for the next cycle; data_out is unchanged.
    - Either way, go to IDLE.
- Strobes:
  - data_valid and frame_err are registered and mutually exclusive.
  - Each is high for exactly one cycle per frame.
- Back-to-back frames:
  - The FSM returns to IDLE at stop-bit centre.
  - A start edge >= OVS/2 cycles later is accepted. This covers the transmitter's single idle bit between frames.
- Reset mid-frame: everything returns to reset values; the partial byte is discarded and no strobe is issued.
- Illegal state encoding: go to IDLE.
- busy: combinational from state; low only in IDLE.

Optional Feature:
- Macro: OPTRX_MAJORITY_EN.
- Defined:
  - Each bit decision (start, data, stop) is the 2-of-3 majority of rx_s at centre-1, centre and centre+1.
  - The decision edge moves to centre+1, so every sample edge above and the strobe latency shift +1 cycle.
  - A single-cycle glitch at the bit centre is rejected.
- Not defined: single sample at the centre with the timing exactly as stated in Behaviour.

Decomposition:
- Package optrx_pkg contains:
  - state_t enum {IDLE, START, DATA, STOP}, 2-bit.
  - LINE_IDLE=1'b0, LINE_START=1'b1, LINE_STOP=1'b0.
  - FRAME_BITS=DATA_W+2.
  - The transmitter shares this package for its frame constants.
- Sub-module rx_sync: 2-flop synchronizer with async reset to LINE_IDLE.

Test Plan (OVS=8, DATA_W=8, rx_in driven 8 clks/bit):
- Idle bit, start, 0x9A LSB first, stop: data_valid pulses once, data_out=0x9A, frame_err stays 0. Strobe timing:
  - without OPTRX_MAJORITY_EN: on the cycle after edge t0+76.
  - with OPTRX_MAJORITY_EN: one cycle later.
- Frames 0x9A then 0x55 separated by one idle bit (transmitter timing): two data_valid pulses, 0x9A then 0x55, and busy drops between them.
- rx_in high for 3 clks, then low: no strobe, busy high for <= OVS/2+1 cycles, FSM returns to IDLE.
- Frame 0xA5 with stop bit driven high: frame_err pulses once, data_valid=0, data_out keeps its previous value (0x55).
- Reset asserted during data bit 4 of 0xFF, released while rx_in is high: no strobe until rx_in goes low. The next clean frame 0x3C is then received correctly.
- OPTRX_MAJORITY_EN defined, frame 0x00 with a 1-cycle high glitch at the centre of bit 3: data_out=0x00, data_valid=1.
